regfile_read_unit: RTL and testbench
====================================

// Module: regfile_read_unit
// PURPOSE
//  Read side of the 64-bit integer register file: NREGS x DATA_W storage, one write port, two read ports.
//  Read requests use a valid/ready handshake; results are registered into a single-entry output buffer
//  that holds until the decode/execute stage consumes them.
//  A same-cycle write to a requested register is bypassed into the result (write-before-read).
//  Register ZERO_REG is hard-wired to zero (XZR).
// PARAMETERS
//  DATA_W    64  register width in bits
//  NREGS     32  number of architectural registers
//  ADDR_W     5  register address width, log2(NREGS)
//  ZERO_REG  31  index that always reads 0 and ignores writes
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst_n       in   1       synchronous active-low reset
//  wr_en       in   1       write strobe
//  wr_addr     in   ADDR_W  write register index
//  wr_data     in   DATA_W  write data
//  req_valid   in   1       read request present
//  req_ready   out  1       unit can accept a request this cycle
//  req_addr_a  in   ADDR_W  read port A index
//  req_addr_b  in   ADDR_W  read port B index
//  out_valid   out  1       rd_data_a/b hold a result
//  out_ready   in   1       consumer takes result this cycle
//  rd_data_a   out  DATA_W  port A result
//  rd_data_b   out  DATA_W  port B result
//  flush       in   1       discard buffered result and any same-cycle request
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all NREGS registers <= 0; out_valid <= 0; rd_data_a/b <= 0. Writes, requests and flush are ignored that cycle.
//  - Write: when wr_en=1 and wr_addr!=ZERO_REG, reg[wr_addr] <= wr_data at posedge. Writes are independent of the read handshake and are never stalled.
//  - req_ready = !out_valid || out_ready (combinational). Accept = req_valid && req_ready && !flush.
//  - Read latency 1: on accept, the next posedge sets out_valid <= 1, rd_data_a <= val(req_addr_a), rd_data_b <= val(req_addr_b).
//  - val(x): 0 if x==ZERO_REG; else wr_data if wr_en && wr_addr==x; else reg[x]. Bypass applies to both ports independently.
//  - Consume: out_valid && out_ready with no accept -> out_valid <= 0; rd_data_a/b hold their last value.
//  - Consume + accept in the same cycle -> new result loaded; out_valid stays 1 (one result per cycle).
//  - Hold: out_valid && !out_ready -> req_ready=0; rd_data_a/b are frozen snapshots. A later write to the same register does NOT update the held result.
//  - flush=1 -> out_valid <= 0 next posedge; any request that cycle is dropped; storage writes still occur.
//  - rst_n=0 overrides flush and all other inputs.
//  - Addresses >= NREGS (when NREGS < 2**ADDR_W) read 0; writes to them are ignored.
// TESTING
//  1. Reset, then req A=3,B=31 -> next cycle out_valid=1, rd_data_a=0, rd_data_b=0.
//  2. Write x5=64'hDEAD_BEEF_0000_0001; next cycle req A=5 -> rd_data_a=64'hDEAD_BEEF_0000_0001.
//  3. Same cycle: wr_en, x7=64'h1234, req A=7,B=7 -> both ports 64'h1234 next cycle (bypass).
//  4. Write x31=64'hFFFF, req A=31 -> rd_data_a=0; x31 stays 0 on all later reads.
//  5. out_ready=0 for 3 cycles after a result: req_ready=0, data frozen through a write to the same register; out_ready=1 + new req -> back-to-back results, out_valid stays 1.
//  6. flush with req_valid=1 -> out_valid=0 next cycle; rst_n=0 mid-hold -> out_valid=0, all registers read 0.

Source files
------------

// File: rtl/regfile_read_unit.sv
// Integer register file read unit: NREGS x DATA_W storage, one write port,
// two bypassed read ports behind a valid/ready handshake and a one-entry result buffer.
module regfile_read_unit #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr_a,
   input  logic [ADDR_W-1:0] req_addr_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              flush
);

   localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W:0]   NREGS_L = (ADDR_W+1)'(NREGS);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic              r_out_valid;
   logic [DATA_W-1:0] r_rd_a;
   logic [DATA_W-1:0] r_rd_b;

   logic              w_wr_ok;
   logic              w_accept;
   logic              w_consume;
   logic [DATA_W-1:0] w_val_a;
   logic [DATA_W-1:0] w_val_b;

   // Zero register and out-of-range indices read as 0; same-cycle write wins over storage.
   function automatic logic [DATA_W-1:0] f_read(
      input logic [ADDR_W-1:0] x,
      input logic [DATA_W-1:0] stored,
      input logic              wr_ok,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      if (x == ZERO_A || {1'b0, x} >= NREGS_L) return '0;
      if (wr_ok && waddr == x)                return wdata;
      return stored;
   endfunction

   always_comb begin
      w_wr_ok   = wr_en && (wr_addr != ZERO_A) && ({1'b0, wr_addr} < NREGS_L);
      req_ready = !r_out_valid || out_ready;
      w_accept  = req_valid && req_ready && !flush;
      w_consume = r_out_valid && out_ready;
      w_val_a   = f_read(req_addr_a, r_regs[req_addr_a], w_wr_ok, wr_addr, wr_data);
      w_val_b   = f_read(req_addr_b, r_regs[req_addr_b], w_wr_ok, wr_addr, wr_data);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_rd_a      <= '0;
         r_rd_b      <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_rd_a      <= w_val_a;
         r_rd_b      <= w_val_b;
      end else if (w_consume) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign rd_data_a = r_rd_a;
   assign rd_data_b = r_rd_b;

endmodule

// File: tb/tb_regfile_read_unit.sv
// Scoreboard bench for regfile_read_unit: driver pushes expected results from an
// array-based register model, a negedge monitor compares whatever the DUT presents.
module tb_regfile_read_unit;

   localparam int DW = 64;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int ZR = 31;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr_a;
   logic [AW-1:0] req_addr_b;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] rd_data_a;
   logic [DW-1:0] rd_data_b;
   logic          flush;

   always #5 clk = ~clk;

   regfile_read_unit #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr_a(req_addr_a),
      .req_addr_b(req_addr_b), .out_valid(out_valid), .out_ready(out_ready),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .flush(flush)
   );

   typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; } res_t;

   int unsigned   n_checks = 0;
   int unsigned   n_pass   = 0;
   logic [DW-1:0] m_regs [NR];
   bit            m_valid  = 1'b0;
   res_t          sbq [$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] m_val(input int x);
      if (x == ZR || x >= NR) return '0;
      if (wr_en && int'(wr_addr) == x) return wr_data;
      return m_regs[x];
   endfunction

   // One clock: evaluate the model against the inputs in force, step it at the edge.
   task automatic tick();
      bit   acc;
      res_t r;
      acc = rst_n && req_valid && (!m_valid || out_ready) && !flush;
      r.a = m_val(int'(req_addr_a));
      r.b = m_val(int'(req_addr_b));
      @(posedge clk);
      if (!rst_n) begin
         foreach (m_regs[i]) m_regs[i] = '0;
         if (m_valid && !out_ready && sbq.size() > 0) void'(sbq.pop_back());
         m_valid = 1'b0;
      end else begin
         if (wr_en && int'(wr_addr) != ZR && int'(wr_addr) < NR) m_regs[wr_addr] = wr_data;
         if (m_valid && !out_ready && flush && sbq.size() > 0) void'(sbq.pop_back());
         if (acc) sbq.push_back(r);
         if (flush)                      m_valid = 1'b0;
         else if (acc)                   m_valid = 1'b1;
         else if (m_valid && out_ready)  m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic idle();
      rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0;
      out_ready = 1'b1; flush = 1'b0;
   endtask

   task automatic req(input int a, input int b);
      req_valid = 1'b1; req_addr_a = AW'(a); req_addr_b = AW'(b);
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
   endtask

   // Monitor: compare presented output with the scoreboard head; pop on consume.
   initial begin
      bit exp_v;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_v = (sbq.size() != 0);
         check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
         check("req_ready", {63'd0, req_ready}, {63'd0, (!exp_v || out_ready)});
         if (out_valid === 1'b1 && exp_v) begin
            check("rd_data_a", rd_data_a, sbq[0].a);
            check("rd_data_b", rd_data_b, sbq[0].b);
            if (out_ready) void'(sbq.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (m_regs[i]) m_regs[i] = '0;
      idle();
      rst_n = 1'b0;
      tick(); tick();
      check("reset_rd_a", rd_data_a, '0);
      check("reset_rd_b", rd_data_b, '0);
      idle();

      // Read after reset, including the zero register.
      req(3, 31); tick(); idle(); tick();

      // Plain write then read.
      wr(5, 64'hDEAD_BEEF_0000_0001); tick(); idle();
      req(5, 3); tick(); idle(); tick();

      // Same-cycle write and read of the same register on both ports.
      wr(7, 64'h1234); req(7, 7); tick(); idle(); tick();

      // Writes to the zero register are discarded.
      wr(31, 64'hFFFF); req(31, 5); tick(); idle();
      req(31, 31); tick(); idle(); tick();

      // Hold for three cycles with a write to the held register, then back-to-back.
      req(7, 5); tick(); idle();
      out_ready = 1'b0;
      wr(7, 64'hAAAA_5555); req(3, 3); tick();
      idle(); out_ready = 1'b0; req(7, 7); tick();
      idle(); out_ready = 1'b0; tick();
      idle(); req(7, 5); tick();
      req(5, 7); tick();
      req(7, 31); tick(); idle(); tick();

      // Flush with a pending request, and flush while holding.
      req(5, 5); flush = 1'b1; tick(); idle(); tick();
      req(5, 7); tick(); idle(); out_ready = 1'b0; flush = 1'b1; tick(); idle(); tick();

      // Reset in the middle of a hold; everything reads 0 afterwards.
      req(5, 7); tick(); idle(); out_ready = 1'b0; tick();
      rst_n = 1'b0; out_ready = 1'b0; flush = 1'b1; wr(5, 64'h1); req(5, 5); tick(); idle();
      req(5, 7); tick(); req(1, 30); tick(); idle(); tick();

      // Randomised traffic with biased address overlap to exercise the bypass.
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         wr_en      = $urandom_range(0, 1) == 1;
         wr_addr    = AW'($urandom_range(0, NR - 1));
         wr_data    = {$urandom, $urandom};
         req_valid  = $urandom_range(0, 3) != 0;
         req_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
         req_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
         out_ready  = $urandom_range(0, 3) != 0;
         flush      = $urandom_range(0, 19) == 0;
         tick();
      end

      idle();
      repeat (4) tick();
      check("drain_empty", 64'(sbq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
